// File: rtl/sm_timer.sv
// Memory-mapped timer/compare peripheral on the data-memory bus.
// Prescaled tick counter with compare match, sticky flag and registered irq.
`timescale 1ns/100ps
module sm_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmAddr,
    input  logic        dmWe,
    input  logic [31:0] dmWData,
    output logic [31:0] dmRData,
    output logic        hit,
    output logic        irq
);

    logic        en_q, en_d;
    logic        ar_q, ar_d;
    logic        ie_q, ie_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic        flag_q, flag_d;
    logic        irq_q, irq_d;

    logic        wr;
    logic [1:0]  sel;
    logic        wr_ctrl, wr_cnt, wr_cmp, wr_stat;
    logic        tick, match;
    logic [1:0]  unused_addr;

    assign hit         = (dmAddr[31:4] == BASE_ADDR[31:4]);
    assign sel         = dmAddr[3:2];
    assign unused_addr = dmAddr[1:0];
    assign wr          = dmWe & hit;
    assign wr_ctrl     = wr && (sel == 2'd0);
    assign wr_cnt      = wr && (sel == 2'd1);
    assign wr_cmp      = wr && (sel == 2'd2);
    assign wr_stat     = wr && (sel == 2'd3);

    assign tick  = en_q && (pc_q == presc_q);
    assign match = tick && (cnt_q == cmp_q);

    // CPU writes are applied last so they override the hardware updates.
    always_comb begin
        en_d    = en_q;
        ar_d    = ar_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        cmp_d   = cmp_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;

        if (!en_q || tick) begin
            pc_d = '0;
        end else begin
            pc_d = pc_q + 16'd1;
        end

        if (tick) begin
            if (!match) begin
                cnt_d = cnt_q + 32'd1;
            end else if (ar_q) begin
                cnt_d = '0;
            end else begin
                en_d = 1'b0;
            end
        end

        if (wr_stat && dmWData[0]) begin
            flag_d = 1'b0;
        end
        if (match) begin
            flag_d = 1'b1;
        end

        if (wr_ctrl) begin
            en_d    = dmWData[0];
            ar_d    = dmWData[1];
            ie_d    = dmWData[2];
            presc_d = dmWData[23:8];
            pc_d    = '0;
        end
        if (wr_cnt) begin
            cnt_d = dmWData;
        end
        if (wr_cmp) begin
            cmp_d = dmWData;
        end

        irq_d = flag_d & ie_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            presc_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            flag_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            en_q    <= en_d;
            ar_q    <= ar_d;
            ie_q    <= ie_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            flag_q  <= flag_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        dmRData = '0;
        if (hit) begin
            case (sel)
                2'd0:    dmRData = {8'h00, presc_q, 5'h00, ie_q, ar_q, en_q};
                2'd1:    dmRData = cnt_q;
                2'd2:    dmRData = cmp_q;
                default: dmRData = {31'h0, flag_q};
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: doc/sm_timer.md
# sm_timer

Memory-mapped timer/compare peripheral that responds on the CPU data-memory bus (dmAddr/dmWe/dmWData/dmRData). It decodes a 16-byte window, returns read data in the same cycle, and counts prescaled clock ticks against a compare value. On a match it raises a sticky flag and an interrupt line. The top level uses `hit` to steer read data and to gate writes to data RAM.

## Interface
- BASE_ADDR, 32'h0000_7F00: byte base of the register window; bits [3:0] ignored.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- dmAddr  in  32  data bus byte address; hit when dmAddr[31:4] == BASE_ADDR[31:4]; register select dmAddr[3:2].
- dmWe  in  1  write strobe; a write takes effect at the clk edge when dmWe & hit.
- dmWData  in  32  write data.
- dmRData  out  32  read data, combinational from address and registers; 0 when not hit.
- hit  out  1  combinational address-window match.
- irq  out  1  flag & CTRL.IE, driven from flops only (glitch-free).

## Operation
- Register map (offset: name):
  - 0x0 CTRL: [0] EN, [1] AR (auto-reload), [2] IE, [23:8] PRESC; other bits read 0.
  - 0x4 CNT: read/write.
  - 0x8 CMP: read/write.
  - 0xC STATUS: [0] FLAG, write-1-to-clear; other bits read 0.
- Reset values: CTRL 0, CNT 0, CMP 32'hFFFF_FFFF, FLAG 0, prescaler counter 0, irq 0.
- Prescaler: 16-bit counter `pc`, advanced only while EN=1.
  - When pc == PRESC, a tick is generated and pc returns to 0; otherwise pc increments.
  - Tick period is PRESC+1 cycles; PRESC=0 gives a tick every cycle.
  - While EN=0, pc holds at 0. Any CTRL write clears pc.
- On a tick:
  - If CNT == CMP: FLAG set. If AR=1, CNT <= 0 and counting continues. If AR=0 (one-shot), CNT holds and EN is cleared by hardware.
  - Else CNT <= CNT + 1, 32-bit modulo, so 32'hFFFF_FFFF wraps to 0.
- Priority, same cycle:
  - A CPU write to CNT overrides the tick update of CNT.
  - A CPU write to CTRL overrides the hardware clear of EN.
  - A STATUS W1C coinciding with a match set leaves FLAG=1 (set wins).
  - Writing 0 to STATUS bit 0 has no effect.
- Writes with hit=0 are ignored. Reads have no side effects.
- Reset asserted mid-count returns every register to its reset value immediately, independent of clk.

## Timing
- Read latency 0: dmRData is valid in the same cycle that dmAddr is presented, which matches the single-cycle CPU lw.
- Write latency 1: the value is readable in the cycle after the write edge.
- A match is evaluated on the tick edge. FLAG and irq rise at that edge and are visible the cycle after it.
- With EN set at edge E, PRESC=p, CNT=0, CMP=c: the first tick is at edge E+p+1, and the match tick is at edge E+(c+1)(p+1).
- irq falls one cycle after the W1C write edge, unless re-set at that same edge.

## Test plan
- Reset/readback: assert rst_n=0, release. Read 0x0/0x4/0x8/0xC at BASE_ADDR -> 0, 0, 32'hFFFF_FFFF, 0. Read address BASE_ADDR+0x10 -> hit=0, dmRData=0.
- One-shot, PRESC=0: write CMP=3, then CTRL=0x5 (EN, IE).
  - FLAG and irq rise 4 cycles after the CTRL write edge.
  - CNT reads 3. CTRL reads 0x4 (EN cleared).
  - CNT stays 3 for a further 10 cycles.
- Prescale/auto-reload: CMP=1, CTRL = PRESC 2 | AR | EN.
  - CNT sequence 0,1,0,1, with each value lasting 3 cycles.
  - FLAG is first set 6 cycles after enable.
- W1C collision: drive a STATUS write of 1 on the exact edge a match occurs -> FLAG remains 1. A second W1C clears it; irq drops the next cycle.
- CNT write priority and wrap:
  - Write CNT=32'hFFFF_FFFF during a tick edge -> reads 32'hFFFF_FFFF. Next tick -> 0.
  - With CMP=5, write CNT=5 -> the match fires on the next tick.
- Asynchronous reset mid-count: pulse rst_n low for 1 ns between edges while EN=1 and CNT=7 -> all registers return to reset values at once, with no clk edge required.
